// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : seq_divider
// Description : 32-bit signed radix-2 restoring divider, one quotient bit
//               per cycle, with divide-by-zero and overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_divider (
    input  logic        clock,
    input  logic        resetn,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        busy,
    output logic        ready,
    output logic        div_zero,
    output logic        ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0]  C_LAST_STEP = 6'd31;
    localparam logic [31:0] C_INT_MIN   = 32'h8000_0000;
    localparam logic [31:0] C_MINUS_ONE = 32'hFFFF_FFFF;

    state_t      r_state;
    logic [31:0] r_rem;
    logic [31:0] r_dvd;
    logic [31:0] r_dsr;
    logic [5:0]  r_cnt;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_dz;
    logic        r_ovf;

    logic [31:0] w_abs_dvd;
    logic [31:0] w_abs_dsr;
    logic [32:0] w_cand;
    logic [32:0] w_diff;
    logic [31:0] w_rem_mag;

    // |0x80000000| wraps back to 0x80000000, which is the correct unsigned magnitude
    assign w_abs_dvd = dividend[31] ? (32'd0 - dividend) : dividend;
    assign w_abs_dsr = divisor[31]  ? (32'd0 - divisor)  : divisor;

    assign w_cand    = {r_rem, r_dvd[31]};
    assign w_diff    = w_cand - {1'b0, r_dsr};

    // A zero divisor never enters RUN, so the dividend magnitude is the remainder
    assign w_rem_mag = r_dz ? r_dvd : r_rem;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_rem     <= 32'd0;
            r_dvd     <= 32'd0;
            r_dsr     <= 32'd0;
            r_cnt     <= 6'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_dz      <= 1'b0;
            r_ovf     <= 1'b0;
            quotient  <= 32'd0;
            remainder <= 32'd0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            div_zero  <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // The ready cycle is still IDLE; a start there is refused
                    if (start && !ready) begin
                        r_neg_q <= dividend[31] ^ divisor[31];
                        r_neg_r <= dividend[31];
                        r_dvd   <= w_abs_dvd;
                        r_dsr   <= w_abs_dsr;
                        r_rem   <= 32'd0;
                        r_cnt   <= 6'd0;
                        r_dz    <= (divisor == 32'd0);
                        r_ovf   <= (dividend == C_INT_MIN) && (divisor == C_MINUS_ONE);
                        busy    <= 1'b1;
                        r_state <= (divisor == 32'd0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    r_rem <= w_diff[32] ? w_cand[31:0] : w_diff[31:0];
                    r_dvd <= {r_dvd[30:0], ~w_diff[32]};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == C_LAST_STEP) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    quotient  <= r_dz ? 32'd0 : (r_neg_q ? (32'd0 - r_dvd) : r_dvd);
                    remainder <= r_neg_r ? (32'd0 - w_rem_mag) : w_rem_mag;
                    div_zero  <= r_dz;
                    ovf       <= r_ovf;
                    ready     <= 1'b1;
                    busy      <= 1'b0;
                    r_state   <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_divider
// Description : Self-checking bench for seq_divider against an arithmetic
//               reference model (C-style truncating division).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

    logic        clock;
    logic        resetn;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        busy;
    logic        ready;
    logic        div_zero;
    logic        ovf;

    int n_tests;
    int n_fail;

    seq_divider u_dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .ready    (ready),
        .div_zero (div_zero),
        .ovf      (ovf)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r,
                                    output logic dz, output logic ov);
        int sa;
        int sb;
        sa = a;
        sb = b;
        dz = 1'b0;
        ov = 1'b0;
        if (sb == 0) begin
            q  = 32'd0;
            r  = a;
            dz = 1'b1;
        end else if (sa == 32'sh8000_0000 && sb == -1) begin
            q  = 32'h8000_0000;
            r  = 32'd0;
            ov = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // One division: latency, results, flags and the single-cycle ready pulse.
    task automatic do_div(input logic [31:0] a, input logic [31:0] b,
                          input bit inject_busy, input bit start_on_ready);
        logic [31:0] eq;
        logic [31:0] er;
        logic        edz;
        logic        eov;
        int          k;
        int          extra;
        ref_div(a, b, eq, er, edz, eov);
        @(negedge clock);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clock);
        #1;
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        k = 0;
        @(negedge clock);
        check_eq("busy_after_accept", 32'(busy), 32'd1);
        while (!ready && k < 40) begin
            if (inject_busy && k == 10) begin
                start    = 1'b1;
                dividend = 32'd9;
                divisor  = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clock);
            k++;
        end
        start = 1'b0;
        check_eq("latency", 32'(k), (b == 32'd0) ? 32'd1 : 32'd33);
        check_eq("quotient", quotient, eq);
        check_eq("remainder", remainder, er);
        check_eq("div_zero", 32'(div_zero), 32'(edz));
        check_eq("ovf", 32'(ovf), 32'(eov));
        if (start_on_ready) begin
            start    = 1'b1;
            dividend = $urandom;
            divisor  = 32'd1;
        end
        @(negedge clock);
        start = 1'b0;
        check_eq("ready_pulse", 32'(ready), 32'd0);
        if (start_on_ready) begin
            check_eq("start_on_ready_ignored", 32'(busy), 32'd0);
            check_eq("quotient_hold", quotient, eq);
            check_eq("remainder_hold", remainder, er);
        end
        if (inject_busy) begin
            extra = 0;
            repeat (40) begin
                @(negedge clock);
                if (ready) extra++;
            end
            check_eq("no_second_ready", 32'(extra), 32'd0);
        end
    endtask

    initial begin
        int cnt;
        logic [31:0] ra;
        logic [31:0] rb;
        n_tests  = 0;
        n_fail   = 0;
        resetn   = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #23;
        check_eq("rst_quotient", quotient, 32'd0);
        check_eq("rst_remainder", remainder, 32'd0);
        check_eq("rst_flags", {28'd0, busy, ready, div_zero, ovf}, 32'd0);
        @(posedge clock);
        #1 resetn = 1'b1;

        do_div(32'd100, 32'd7, 1'b0, 1'b0);
        do_div(32'hFFFF_FF9C, 32'd7, 1'b0, 1'b1);
        do_div(32'd100, 32'hFFFF_FFF9, 1'b0, 1'b0);
        do_div(32'd5, 32'd0, 1'b0, 1'b0);
        do_div(32'h8000_0000, 32'd0, 1'b0, 1'b0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        do_div(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        do_div(32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 1'b0);
        do_div(32'h8000_0000, 32'd1, 1'b0, 1'b0);
        do_div(32'd20, 32'd3, 1'b1, 1'b0);

        // Reset in the middle of RUN aborts the operation
        @(negedge clock);
        start    = 1'b1;
        dividend = 32'd20;
        divisor  = 32'd3;
        @(negedge clock);
        start = 1'b0;
        repeat (10) @(negedge clock);
        #1 resetn = 1'b0;
        #1;
        check_eq("midrst_outputs", quotient | remainder, 32'd0);
        check_eq("midrst_flags", {28'd0, busy, ready, div_zero, ovf}, 32'd0);
        @(posedge clock);
        #1 resetn = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clock);
            if (ready || busy) cnt++;
        end
        check_eq("midrst_no_ready", 32'(cnt), 32'd0);
        do_div(32'd20, 32'd3, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case (i % 4)
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 20);
                2:       rb = 32'd0 - $urandom_range(1, 300);
                default: rb = (i % 8 == 3) ? 32'd0 : ($urandom >> $urandom_range(0, 31));
            endcase
            do_div(ra, rb, 1'b0, (i % 5) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
